// File: rtl/pio_debounce_capture.sv
// pio_debounce_capture
//   Avalon-MM input PIO for push-buttons and slide switches. Every channel is
//   passed through a two-flop synchroniser and a per-channel debounce counter,
//   then edge-detected. Selected edges are latched in a write-one-to-clear
//   capture register. The capture register drives a maskable, registered level
//   interrupt.
//
//   Register map (word address):
//     0 DATA     RO     debounced levels, zero-extended
//     1 IRQMASK  RW     bits [WIDTH-1:0]
//     2 reserved RO     reads 0
//     3 EDGECAP  R/W1C  captured edges; set wins over a same-cycle clear
//
// Ports
//   clk_clk        system clock
//   reset_reset_n  asynchronous reset, active low
//   in_port        raw asynchronous input pins
//   address        Avalon-MM word address
//   read, write    Avalon-MM strobes (no waitrequest)
//   writedata      write data
//   readdata       registered read data, valid one clock after read
//   irq            level interrupt, |(edge_cap & irq_mask) registered
module pio_debounce_capture #(
  parameter int unsigned       WIDTH           = 4,
  parameter int unsigned       DEBOUNCE_CYCLES = 50000,
  parameter int unsigned       CNT_W           = 16,
  parameter int unsigned       EDGE_MODE       = 1,
  parameter logic [WIDTH-1:0]  RESET_LEVEL     = '1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [WIDTH-1:0]  in_port,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] cap_clr;
  logic             mask_we;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Synchroniser, debounce and edge history. prev resets to the same level as
  // stable so the reset value itself never looks like an edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1  <= RESET_LEVEL;
      sync2  <= RESET_LEVEL;
      stable <= RESET_LEVEL;
      prev   <= RESET_LEVEL;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= stable;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rise     = stable & ~prev;
    fall     = ~stable & prev;
    edge_sel = '0;
    case (EDGE_MODE)
      0:       edge_sel = rise;
      1:       edge_sel = fall;
      default: edge_sel = rise | fall;
    endcase
  end

  always_comb begin
    cap_clr = '0;
    mask_we = 1'b0;
    if (write && (address == 2'd3)) begin
      cap_clr = writedata[WIDTH-1:0];
    end
    if (write && (address == 2'd1)) begin
      mask_we = 1'b1;
    end
    unused_wdata = ^writedata;
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = stable;
      2'd1:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_cap;
      default: rd_mux = '0;
    endcase
  end

  // Clear is applied before the new edges are OR-ed in, so a coincident edge
  // survives its own W1C.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edge_cap <= '0;
      irq_mask <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      edge_cap <= (edge_cap & ~cap_clr) | edge_sel;
      if (mask_we) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      if (read) begin
        readdata <= rd_mux;
      end
      irq <= |(edge_cap & irq_mask);
    end
  end

endmodule

// File: tb/tb_pio_debounce_capture.sv
module tb_pio_debounce_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  in_port;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic        irq_a;
  logic        irq_b;

  logic        irq_chk;
  logic        rd_seen  = 1'b0;
  logic        irq_seen = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } exp_t;

  exp_t rdq[$];
  exp_t irqq[$];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Falling-edge capture, shared by both instances.
  pio_debounce_capture #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(4), .EDGE_MODE(1), .RESET_LEVEL(4'hF)
  ) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n), .in_port(in_port),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(rd_a), .irq(irq_a)
  );

  // Both-edge capture.
  pio_debounce_capture #(
    .WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(4), .EDGE_MODE(2), .RESET_LEVEL(4'hF)
  ) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .in_port(in_port),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(rd_b), .irq(irq_b)
  );

  always @(posedge clk) begin
    rd_seen  <= read;
    irq_seen <= irq_chk;
  end

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
  endtask

  // Monitor: a read sampled at the last posedge has its data on readdata now.
  always @(negedge clk) begin
    exp_t e;
    if (rd_seen === 1'b1) begin
      if (rdq.size() == 0) begin
        total++;
        $display("FAIL rd_underflow: got read response expected none");
      end else begin
        e = rdq.pop_front();
        check({e.name, "_a"}, rd_a, e.exp_a);
        check({e.name, "_b"}, rd_b, e.exp_b);
      end
    end
    if (irq_seen === 1'b1) begin
      if (irqq.size() == 0) begin
        total++;
        $display("FAIL irq_underflow: got irq sample expected none");
      end else begin
        e = irqq.pop_front();
        check({e.name, "_a"}, {31'd0, irq_a}, e.exp_a);
        check({e.name, "_b"}, {31'd0, irq_b}, e.exp_b);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    read    = 1'b0;
    write   = 1'b0;
    irq_chk = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] ea, input logic [31:0] eb,
                    input string n);
    exp_t e;
    e.name = n; e.exp_a = ea; e.exp_b = eb;
    address = a;
    read    = 1'b1;
    rdq.push_back(e);
    tick();
  endtask

  // Sets up a write for the coming posedge; caller ticks.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
  endtask

  // Samples irq right after the coming posedge; caller ticks.
  task automatic chk_irq(input logic ea, input logic eb, input string n);
    exp_t e;
    e.name = n; e.exp_a = {31'd0, ea}; e.exp_b = {31'd0, eb};
    irq_chk = 1'b1;
    irqq.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_port = 4'hF; address = 2'd0;
    read = 1'b0; write = 1'b0; writedata = '0; irq_chk = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state and read-only behaviour
    rd(2'd0, 32'hF, 32'hF, "rst_data");
    rd(2'd3, 32'h0, 32'h0, "rst_edgecap");
    rd(2'd1, 32'h0, 32'h0, "rst_mask");
    rd(2'd2, 32'h0, 32'h0, "rst_resv");
    chk_irq(1'b0, 1'b0, "rst_irq"); tick();
    wr(2'd0, 32'h0); tick();
    wr(2'd2, 32'hFFFF_FFFF); tick();
    rd(2'd0, 32'hF, 32'hF, "data_ro");
    rd(2'd2, 32'h0, 32'h0, "resv_ro");

    // Press key 0: stable changes exactly 6 clocks after the pin
    in_port = 4'hE;
    for (int k = 0; k < 6; k++) rd(2'd0, 32'hF, 32'hF, "lat_pre");
    rd(2'd0, 32'hE, 32'hE, "lat_post");
    rd(2'd3, 32'h1, 32'h1, "fall_cap");
    chk_irq(1'b0, 1'b0, "irq_masked"); tick();

    // Bounce on key 1 shorter than the debounce window
    in_port = 4'hC;
    repeat (3) tick();
    in_port = 4'hE;
    repeat (8) tick();
    rd(2'd0, 32'hE, 32'hE, "bounce_data");
    rd(2'd3, 32'h1, 32'h1, "bounce_cap");

    // Unmasking a pending edge, then clearing it
    wr(2'd1, 32'hFFFF_FFF1); chk_irq(1'b0, 1'b0, "irq_pre"); tick();
    chk_irq(1'b1, 1'b1, "irq_mask_on"); tick();
    rd(2'd1, 32'h1, 32'h1, "mask_rd");
    wr(2'd3, 32'h1); chk_irq(1'b1, 1'b1, "irq_clr_same"); tick();
    chk_irq(1'b0, 1'b0, "irq_clr_next"); tick();
    rd(2'd3, 32'h0, 32'h0, "cap_cleared");

    // Key 2 edge lands in the same clock as a W1C of bit 2
    in_port = 4'hA;
    repeat (6) tick();
    wr(2'd3, 32'h4); tick();
    rd(2'd3, 32'h4, 32'h4, "set_wins");
    rd(2'd0, 32'hA, 32'hA, "data_a");
    wr(2'd3, 32'hF); tick();
    rd(2'd3, 32'h0, 32'h0, "w1c_all");

    // Release keys 0 and 2: only the both-edge instance captures
    in_port = 4'hF;
    repeat (8) tick();
    rd(2'd3, 32'h0, 32'h5, "rise_cap");
    chk_irq(1'b0, 1'b1, "irq_b_rise"); tick();
    wr(2'd1, 32'h0); chk_irq(1'b0, 1'b1, "irq_drop_same"); tick();
    chk_irq(1'b0, 1'b0, "irq_drop_next"); tick();
    wr(2'd3, 32'hF); tick();

    // Reset at cnt=2 with the pin restored during reset
    in_port = 4'h7;
    repeat (4) tick();
    rst_n = 1'b0; in_port = 4'hF;
    repeat (2) tick();
    rst_n = 1'b1;
    rd(2'd0, 32'hF, 32'hF, "post_rst_data");
    repeat (8) tick();
    rd(2'd0, 32'hF, 32'hF, "post_rst_data2");
    rd(2'd3, 32'h0, 32'h0, "post_rst_cap");
    chk_irq(1'b0, 1'b0, "post_rst_irq"); tick();

    // Reset at cnt=2 with the pin still low: the count restarts from zero
    in_port = 4'h7;
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) rd(2'd0, 32'hF, 32'hF, "discard_pre");
    rd(2'd0, 32'h7, 32'h7, "discard_post");
    in_port = 4'hF;
    repeat (4) tick();

    if (rdq.size() != 0 || irqq.size() != 0) begin
      total++;
      $display("FAIL queue_drain: got %0d/%0d pending expected 0/0", rdq.size(), irqq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
